ssd_scan_controller: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It sequences digit slots with a dead-time blanking interval between them to suppress ghosting. It decodes hex nibbles with optional leading-zero suppression and commits new display values only at frame boundaries, so a value never tears across a frame. It sits in the top level between game/status logic (the value producer) and the An*/Ca..Cg/Dp pins.

---
 rtl/ssd_scan_if.sv | 27 ++
 rtl/ssd_scan_controller.sv | 173 +++++++++++++++++
 tb/tb_ssd_scan_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Producer/display-side bundle for the seven-segment scan controller.
interface ssd_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    load_ack;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    // Value producer / pin-side view
    modport master (
        output value_in, load, digit_en, dp_in, lz_suppress,
        input  load_ack, an, seg, dp, frame_done
    );

    // Scan controller view
    modport slave (
        input  value_in, load, digit_en, dp_in, lz_suppress,
        output load_ack, an, seg, dp, frame_done
    );
endinterface

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed common-anode 7-segment scanner with blanking dead time,
// hex decode, leading-zero suppression and frame-aligned value commit.
module ssd_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_CYCLES = 262144,
    parameter int unsigned BLANK_CYCLES = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset,
    ssd_scan_if.slave   bus
);
    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [VAL_W-1:0]      staging_q, staging_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0] zero_above;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  digit_lit;
    logic                  boundary;

    // Active-low abcdefg pattern for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Current digit nibble and "this nibble and everything above it is zero" map
    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        cur_nib    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            zero_above[i] = zero_run;
            if (idx_q == IDX_W'(i)) begin
                cur_nib = shadow_q[4*i +: 4];
            end
        end
    end

    // Digit 0 is never suppressed so a zero value still shows "0"
    assign digit_lit = bus.digit_en[idx_q]
                     && !(bus.lz_suppress && (idx_q != '0) && zero_above[idx_q]);

    // Scan sequencing, output decode and frame-aligned commit
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        staging_d    = staging_q;
        pending_d    = pending_q;
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        boundary     = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (digit_lit) begin
                    an_d  = ~(NUM_DIGITS'(1) << idx_q);
                    seg_d = hex_to_seg(cur_nib);
                    dp_d  = ~bus.dp_in[idx_q];
                end
                if (cnt_q == DIGIT_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    boundary = (idx_q == IDX_LAST);
                    idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase

        // A load landing on the boundary bypasses staging and commits directly
        if (boundary) begin
            frame_done_d = 1'b1;
            if (pending_q || bus.load) begin
                shadow_d   = bus.load ? bus.value_in : staging_q;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end
        end else if (bus.load) begin
            staging_d = bus.value_in;
            pending_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            staging_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: the driver pushes expected lit
// digits and per-frame load_ack values; the monitor pops them as the DUT
// presents each lit digit run and each frame_done pulse.
module tb_ssd_scan_controller;
    localparam int unsigned ND = 8;
    localparam int unsigned DC = 8;
    localparam int unsigned BC = 2;
    localparam int FRAME = 80;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } lit_t;

    logic clk = 1'b0;
    logic rst;

    ssd_scan_if #(.NUM_DIGITS(ND)) bus ();

    ssd_scan_controller #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .ClkPort(clk),
        .Reset  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    lit_t lit_q[$];
    bit   fd_q[$];
    logic [31:0] mdl_shadow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Segment table typed in from the display datasheet
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // ---------------- monitor ----------------
    lit_t run;
    int   run_len;
    bit   run_stable;
    bit   in_run   = 1'b0;
    bit   rst_seen = 1'b0;
    int   cyc      = 0;
    int   last_fd  = -1;

    task automatic end_run();
        lit_t e;
        if (lit_q.size() == 0) begin
            chk("lit_unexpected_an", 32'(run.an), 32'hFF);
        end else begin
            e = lit_q.pop_front();
            chk("lit_an", 32'(run.an), 32'(e.an));
            chk("lit_seg", 32'(run.seg), 32'(e.seg));
            chk("lit_dp", 32'(run.dp), 32'(e.dp));
            chk("lit_len", 32'(run_len), 32'(DC));
            chk("lit_stable", 32'(run_stable), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!rst_seen) begin
                lit_q.delete();
                fd_q.delete();
            end
            rst_seen = 1'b1;
            in_run   = 1'b0;
            cyc      = 0;
            last_fd  = -1;
        end else begin
            rst_seen = 1'b0;
            cyc++;
            chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
            if (in_run && bus.an != run.an) begin
                end_run();
                in_run = 1'b0;
            end
            if (bus.an == 8'hFF) begin
                chk("blank_seg", 32'(bus.seg), 32'h7F);
                chk("blank_dp", 32'(bus.dp), 32'd1);
            end else if (!in_run) begin
                in_run     = 1'b1;
                run        = '{an: bus.an, seg: bus.seg, dp: bus.dp};
                run_len    = 1;
                run_stable = 1'b1;
            end else begin
                run_len++;
                if (bus.seg != run.seg || bus.dp != run.dp) run_stable = 1'b0;
            end
            if (bus.frame_done) begin
                if (last_fd < 0) chk("first_frame_done", 32'(cyc), 32'(FRAME));
                else             chk("frame_period", 32'(cyc - last_fd), 32'(FRAME));
                last_fd = cyc;
                if (fd_q.size() == 0) chk("frame_done_unexpected", 32'd1, 32'd0);
                else                  chk("load_ack", 32'(bus.load_ack), 32'(fd_q.pop_front()));
            end else begin
                chk("load_ack_stray", 32'(bus.load_ack), 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic start_frame(input logic [31:0] shv, input logic [7:0] en,
                               input logic [7:0] dpv, input bit lz);
        logic [3:0] nib;
        bit         sup;
        bus.digit_en    = en;
        bus.dp_in       = dpv;
        bus.lz_suppress = lz;
        for (int i = 0; i < 8; i++) begin
            nib = shv[4*i +: 4];
            sup = lz && (i != 0) && ((shv >> (4*i)) == 32'd0);
            if (en[i] && !sup)
                lit_q.push_back('{an: ~(8'd1 << i), seg: hex7(nib), dp: ~dpv[i]});
        end
    endtask

    // One 80-cycle frame, called at the cycle frame_done becomes visible (or at reset release)
    task automatic run_frame(input bit rel, input logic [7:0] en, input logic [7:0] dpv, input bit lz,
                             input logic [31:0] l1v, input int l1c,
                             input logic [31:0] l2v, input int l2c);
        start_frame(mdl_shadow, en, dpv, lz);
        fd_q.push_back(l1c != 0);
        if (rel) rst = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (rel) begin
                if (c == 1 || c == 2) chk("first_slot_blank", 32'(bus.an), 32'hFF);
                if (c == 3) begin
                    chk("first_slot_an", 32'(bus.an), 32'hFE);
                    chk("first_slot_seg", 32'(bus.seg), 32'(7'b0000001));
                end
                if (c == 10) chk("first_slot_last", 32'(bus.an), 32'hFE);
                if (c == 11) chk("first_slot_end", 32'(bus.an), 32'hFF);
            end
            #1;
            bus.load = 1'b0;
            if (l1c == c) begin bus.value_in = l1v; bus.load = 1'b1; end
            if (l2c == c) begin bus.value_in = l2v; bus.load = 1'b1; end
        end
        if (l2c != 0)      mdl_shadow = l2v;
        else if (l1c != 0) mdl_shadow = l1v;
    endtask

    // Reset hits three cycles into digit 4's visible slot
    task automatic reset_mid_frame();
        start_frame(mdl_shadow, 8'hFF, 8'h00, 1'b0);
        for (int c = 1; c <= 45; c++) @(negedge clk);
        chk("pre_reset_an", 32'(bus.an), 32'hEF);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(bus.an), 32'hFF);
        chk("async_rst_seg", 32'(bus.seg), 32'h7F);
        chk("async_rst_dp", 32'(bus.dp), 32'd1);
        mdl_shadow = 32'd0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.value_in    = '0;
        bus.load        = 1'b0;
        bus.digit_en    = '1;
        bus.dp_in       = '0;
        bus.lz_suppress = 1'b0;
        mdl_shadow      = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_load_ack", 32'(bus.load_ack), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        #1;

        run_frame(1'b1, 8'hFF, 8'h00, 1'b0, 32'h0,        0,  32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b0, 32'h0123ABCD, 20, 32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b0, 32'h0,        0,  32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b1, 32'h00000050, 5,  32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b1, 32'h00000000, 5,  32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b1, 32'h11111111, 5,  32'h22222222, 30);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b0, 32'h33333333, 79, 32'h0,        0);
        run_frame(1'b0, 8'h0F, 8'h01, 1'b0, 32'h0,        0,  32'h0,        0);
        reset_mid_frame();
        run_frame(1'b1, 8'hFF, 8'h00, 1'b0, 32'h456789EF, 40, 32'h0,        0);
        run_frame(1'b0, 8'hFF, 8'h00, 1'b0, 32'h0,        0,  32'h0,        0);

        repeat (3) @(negedge clk);
        chk("lit_queue_drained", 32'(lit_q.size()), 32'd0);
        chk("frame_queue_drained", 32'(fd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
